// File: rtl/inst_sram_axi_rd_bridge.sv
// Instruction-fetch sram-like to AXI4 read-only bridge.
// Single-beat in-order reads with a constant ARID. Up to MAX_OUTSTANDING
// requests may be accepted but not yet answered. The write side is tied off.
//
// Handshake rules: an AR transfer happens on a rising edge where
// arvalid && arready. An R transfer happens where rvalid && rready. arvalid,
// araddr and arsize stay stable until the AR transfer completes. On the IF side,
// addr_ok and data_ok are single-cycle pulses, and the IF stage must not stall them.
module inst_sram_axi_rd_bridge #(
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [3:0]  ARID_VAL        = 4'h0,
    localparam int         CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inst_sram_req,
    input  logic             inst_sram_wr,
    input  logic [1:0]       inst_sram_size,
    input  logic [3:0]       inst_sram_wstrb,
    input  logic [31:0]      inst_sram_addr,
    input  logic [31:0]      inst_sram_wdata,
    output logic             inst_sram_addr_ok,
    output logic             inst_sram_data_ok,
    output logic [31:0]      inst_sram_rdata,
    output logic [3:0]       arid,
    output logic [31:0]      araddr,
    output logic [7:0]       arlen,
    output logic [2:0]       arsize,
    output logic [1:0]       arburst,
    output logic [1:0]       arlock,
    output logic [3:0]       arcache,
    output logic [2:0]       arprot,
    output logic             arvalid,
    input  logic             arready,
    input  logic [3:0]       rid,
    input  logic [31:0]      rdata,
    input  logic [1:0]       rresp,
    input  logic             rlast,
    input  logic             rvalid,
    output logic             rready,
    output logic             axi_rd_err,
    output logic             dbg_state,
    output logic [CNT_W-1:0] dbg_cnt
);

    typedef enum logic {
        IDLE    = 1'b0,
        AR_WAIT = 1'b1
    } ar_state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    ar_state_e        state_q, state_d;
    logic [31:0]      araddr_q, araddr_d;
    logic [1:0]       size_q, size_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             r_hs;

    // Write data, strobes and rid carry no information for a single-ID fetch path.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, inst_sram_wstrb, inst_sram_wdata, rid};

    // Accept/return decisions and next-state for the AR FSM, counter and error flag.
    always_comb begin
        state_d           = state_q;
        araddr_d          = araddr_q;
        size_d            = size_q;
        cnt_d             = cnt_q;
        err_d             = err_q;
        inst_sram_addr_ok = !reset && inst_sram_req && !inst_sram_wr
                            && (state_q == IDLE) && (cnt_q < CNT_MAX);
        r_hs              = !reset && rvalid;
        inst_sram_data_ok = r_hs && (cnt_q != '0);

        case (state_q)
            IDLE: begin
                if (inst_sram_addr_ok) begin
                    state_d  = AR_WAIT;
                    araddr_d = inst_sram_addr;
                    size_d   = inst_sram_size;
                end
            end
            AR_WAIT: begin
                if (arready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Simultaneous accept and return leave the count unchanged.
        case ({inst_sram_addr_ok, inst_sram_data_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        // A stray beat, a non-OKAY response or a missing rlast is recorded, not dropped.
        if (r_hs && ((rresp != 2'b00) || !rlast || (cnt_q == '0))) err_d = 1'b1;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            araddr_q <= '0;
            size_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
            size_q   <= size_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign arvalid         = (state_q == AR_WAIT);
    assign araddr          = araddr_q;
    assign arsize          = {1'b0, size_q};
    assign arid            = ARID_VAL;
    assign arlen           = 8'd0;
    assign arburst         = 2'b01;
    assign arlock          = 2'b00;
    assign arcache         = 4'b0000;
    assign arprot          = 3'b000;
    assign rready          = !reset;
    assign inst_sram_rdata = rdata;
    assign axi_rd_err      = err_q;
    assign dbg_state       = state_q;
    assign dbg_cnt         = cnt_q;

endmodule
